mux_nx1_reg: RTL and testbench
==============================

MUX_NX1_REG -- requirements
Module: mux_nx1_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width of each channel and of y.
REQ-002 SHALL have parameter SEL_W, default 2: select width; channel count N = 2**SEL_W.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port a, input, N*WIDTH: packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-006 SHALL have port a_valid, input, N: channel i offers data when a_valid[i]=1.
REQ-007 SHALL have port a_ready, output, N: channel i data is accepted in a cycle with a_valid[i]=1 and a_ready[i]=1.
REQ-008 SHALL have port sel, input, SEL_W: channel index used in fixed mode.
REQ-009 SHALL have port mode, input, 1: 0 = fixed select by sel; 1 = round-robin.
REQ-010 SHALL have port y, output, WIDTH: registered output data.
REQ-011 SHALL have port y_valid, output, 1: y holds valid data.
REQ-012 SHALL have port y_ready, input, 1: the consumer takes y in a cycle with y_valid=1 and y_ready=1.
REQ-013 SHALL have port grant, output, SEL_W: index of the channel whose data is currently in y.

Function
REQ-014 SHALL hold exactly one output entry; can_load = !y_valid || y_ready.
REQ-015 SHALL drive a_ready combinationally: a_ready[c]=can_load for the chosen channel c only, 0 for all others.
REQ-016 SHALL choose c = sel in fixed mode, regardless of a_valid.
REQ-017 SHALL choose c in round-robin mode as the first i with a_valid[i]=1, scanning ptr, ptr+1, ... modulo N; with no a_valid bit set, SHALL drive all a_ready to 0.
REQ-018 SHALL, on an accept (a_valid[c] && a_ready[c]), register y <= channel c data, grant <= c, y_valid <= 1 on that edge (1-cycle latency).
REQ-019 SHALL, when can_load=1 and no accept occurs, clear y_valid on the edge, holding y and grant unchanged.
REQ-020 SHALL, when y_valid=1 and y_ready=0, hold y, y_valid and grant stable.
REQ-021 SHALL accept a new word and pop the old one on the same edge when y_valid=1 and y_ready=1 (full throughput, one word per cycle).
REQ-022 SHALL update the round-robin pointer to ptr <= (c+1) mod N on every round-robin accept, wrapping from N-1 to 0; ptr SHALL be unchanged otherwise, including in fixed mode.
REQ-023 SHALL apply a mode or sel change from the next selection only; the word already in y is unaffected.

Reset
REQ-024 SHALL, when rst=1 at a clk edge, set y=0, y_valid=0, grant=0, ptr=0, aborting any held word; rst SHALL take priority over accept and pop.
REQ-025 SHALL force a_ready to 0 in every cycle with rst=1.

Configuration
REQ-026 SHALL, with macro MUX_NX1_REG_CNT_EN defined, add output port xfer_cnt (16 bits) counting output transfers (y_valid && y_ready), reset to 0, wrapping from 0xFFFF to 0x0000.
REQ-027 SHALL, with MUX_NX1_REG_CNT_EN undefined, have neither the xfer_cnt port nor the counter; all other behaviour is identical.

Verification (WIDTH=8, SEL_W=2)
REQ-028 SHALL test fixed mode: mode=0, sel=2, a=0x44_33_22_11, a_valid=4'b0100, y_ready=1 -> a_ready=4'b0100; next cycle y=0x33, grant=2, y_valid=1.
REQ-029 SHALL test backpressure: y_valid=1, y=0x33, y_ready=0 for 3 cycles with new data offered -> a_ready=0, and y and grant unchanged for all 3 cycles.
REQ-030 SHALL test round-robin fairness and wrap: mode=1, a_valid=4'b1111, y_ready=1 held -> grant sequence 0,1,2,3,0 on consecutive cycles.
REQ-031 SHALL test round-robin skip: mode=1, ptr=1, a_valid=4'b1001 -> grant=3, then ptr=0 and next grant=0.
REQ-032 SHALL test reset mid-operation: rst=1 while y_valid=1 and y_ready=0 -> next cycle y=0, y_valid=0, grant=0, and a_ready=0 during reset.
REQ-033 SHALL test the counter with MUX_NX1_REG_CNT_EN defined: 5 transfers -> xfer_cnt=5; with the counter preloaded by running to 0xFFFF, one more transfer -> xfer_cnt=0x0000.

Source files
------------

// File: rtl/mux_nx1_reg.sv
// N:1 registered multiplexer with valid/ready handshakes, fixed or round-robin selection.
// Optional 16-bit output-transfer counter enabled by defining MUX_NX1_REG_CNT_EN.
module mux_nx1_reg #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SEL_W = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [(2**SEL_W)*WIDTH-1:0]   a,
    input  logic [(2**SEL_W)-1:0]         a_valid,
    output logic [(2**SEL_W)-1:0]         a_ready,
    input  logic [SEL_W-1:0]              sel,
    input  logic                          mode,
    output logic [WIDTH-1:0]              y,
    output logic                          y_valid,
    input  logic                          y_ready,
    output logic [SEL_W-1:0]              grant
`ifdef MUX_NX1_REG_CNT_EN
    ,
    output logic [15:0]                   xfer_cnt
`endif
);

    localparam int unsigned N = 2**SEL_W;

    logic [WIDTH-1:0] y_q;
    logic             y_valid_q;
    logic [SEL_W-1:0] grant_q;
    logic [SEL_W-1:0] ptr_q;

    logic             can_load;
    logic [SEL_W-1:0] rr_idx;
    logic             rr_found;
    logic [SEL_W-1:0] chosen;
    logic             chosen_ok;
    logic             accept;

    assign can_load = !y_valid_q || y_ready;

    // First requesting channel at or after ptr; SEL_W-bit addition wraps modulo N.
    always_comb begin
        rr_idx   = ptr_q;
        rr_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!rr_found && a_valid[ptr_q + SEL_W'(k)]) begin
                rr_idx   = ptr_q + SEL_W'(k);
                rr_found = 1'b1;
            end
        end
    end

    assign chosen    = mode ? rr_idx : sel;
    assign chosen_ok = mode ? rr_found : 1'b1;

    always_comb begin
        a_ready = '0;
        if (!rst && chosen_ok) begin
            a_ready[chosen] = can_load;
        end
    end

    assign accept = !rst && chosen_ok && can_load && a_valid[chosen];

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q       <= '0;
            y_valid_q <= 1'b0;
            grant_q   <= '0;
            ptr_q     <= '0;
        end else if (accept) begin
            y_q       <= a[chosen*WIDTH +: WIDTH];
            y_valid_q <= 1'b1;
            grant_q   <= chosen;
            if (mode) begin
                ptr_q <= chosen + SEL_W'(1);
            end
        end else if (can_load) begin
            y_valid_q <= 1'b0;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign grant   = grant_q;

`ifdef MUX_NX1_REG_CNT_EN
    logic [15:0] xfer_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt_q <= '0;
        end else if (y_valid_q && y_ready) begin
            xfer_cnt_q <= xfer_cnt_q + 16'd1;
        end
    end

    assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_mux_nx1_reg.sv
// Self-checking bench for mux_nx1_reg (WIDTH=8, SEL_W=2); vector table plus scoreboard queue.
// Counter checks run only when MUX_NX1_REG_CNT_EN is defined.
module tb_mux_nx1_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a;
    logic [3:0]  a_valid;
    logic [3:0]  a_ready;
    logic [1:0]  sel;
    logic        mode;
    logic [7:0]  y;
    logic        y_valid;
    logic        y_ready;
    logic [1:0]  grant;
`ifdef MUX_NX1_REG_CNT_EN
    logic [15:0] xfer_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       rst;
        logic       mode;
        logic [1:0] sel;
        logic [3:0] av;
        logic       yr;
        logic [3:0] ar;
        logic       v;
        logic [7:0] y;
        logic [1:0] g;
    } vec_t;

    typedef struct {
        logic       v;
        logic [7:0] y;
        logic [1:0] g;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    mux_nx1_reg #(
        .WIDTH (8),
        .SEL_W (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .sel      (sel),
        .mode     (mode),
        .y        (y),
        .y_valid  (y_valid),
        .y_ready  (y_ready),
        .grant    (grant)
`ifdef MUX_NX1_REG_CNT_EN
        ,
        .xfer_cnt (xfer_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic m, input logic [1:0] s,
                                input logic [3:0] av, input logic yr, input logic [3:0] ar,
                                input logic v, input logic [7:0] yy, input logic [1:0] g);
        vec_t t;
        t.rst = r; t.mode = m; t.sel = s; t.av = av; t.yr = yr;
        t.ar = ar; t.v = v; t.y = yy; t.g = g;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s scoreboard: got empty queue, expected an entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, " y_valid"}, {31'd0, y_valid}, {31'd0, e.v});
            check({tag, " y"},       {24'd0, y},       {24'd0, e.y});
            check({tag, " grant"},   {30'd0, grant},   {30'd0, e.g});
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        rst     = v.rst;
        mode    = v.mode;
        sel     = v.sel;
        a_valid = v.av;
        y_ready = v.yr;
        e.v = v.v; e.y = v.y; e.g = v.g;
        sb.push_back(e);
        #1;
        check($sformatf("v%0d a_ready", idx), {28'd0, a_ready}, {28'd0, v.ar});
        @(posedge clk);
        #1;
        pop_check($sformatf("v%0d", idx));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not complete, expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        a = 32'h4433_2211;
        // rst mode sel av yr | a_ready  next: y_valid y grant
        vecs.push_back(mk(0, 0, 2'd2, 4'b0100, 1, 4'b0100, 1, 8'h33, 2'd2)); // fixed sel=2
        vecs.push_back(mk(0, 0, 2'd1, 4'b1111, 0, 4'b0000, 1, 8'h33, 2'd2)); // backpressure x3
        vecs.push_back(mk(0, 0, 2'd1, 4'b1111, 0, 4'b0000, 1, 8'h33, 2'd2));
        vecs.push_back(mk(0, 0, 2'd1, 4'b1111, 0, 4'b0000, 1, 8'h33, 2'd2));
        vecs.push_back(mk(0, 0, 2'd0, 4'b0000, 1, 4'b0001, 0, 8'h33, 2'd2)); // ready w/o valid
        vecs.push_back(mk(0, 0, 2'd1, 4'b0010, 1, 4'b0010, 1, 8'h22, 2'd1));
        vecs.push_back(mk(0, 1, 2'd0, 4'b1111, 1, 4'b0001, 1, 8'h11, 2'd0)); // RR 0,1,2,3,0
        vecs.push_back(mk(0, 1, 2'd0, 4'b1111, 1, 4'b0010, 1, 8'h22, 2'd1));
        vecs.push_back(mk(0, 1, 2'd0, 4'b1111, 1, 4'b0100, 1, 8'h33, 2'd2));
        vecs.push_back(mk(0, 1, 2'd0, 4'b1111, 1, 4'b1000, 1, 8'h44, 2'd3));
        vecs.push_back(mk(0, 1, 2'd0, 4'b1111, 1, 4'b0001, 1, 8'h11, 2'd0));
        vecs.push_back(mk(0, 1, 2'd0, 4'b1001, 1, 4'b1000, 1, 8'h44, 2'd3)); // skip from ptr=1
        vecs.push_back(mk(0, 1, 2'd0, 4'b1001, 1, 4'b0001, 1, 8'h11, 2'd0)); // wrap to 0
        vecs.push_back(mk(0, 1, 2'd0, 4'b0000, 1, 4'b0000, 0, 8'h11, 2'd0)); // RR idle
        vecs.push_back(mk(0, 1, 2'd0, 4'b0100, 0, 4'b0100, 1, 8'h33, 2'd2)); // ptr=1 -> 2
        vecs.push_back(mk(0, 0, 2'd0, 4'b0001, 0, 4'b0000, 1, 8'h33, 2'd2)); // mode change held
        vecs.push_back(mk(0, 0, 2'd0, 4'b0001, 1, 4'b0001, 1, 8'h11, 2'd0)); // ptr stays 3
        vecs.push_back(mk(0, 1, 2'd0, 4'b0111, 1, 4'b0001, 1, 8'h11, 2'd0)); // ptr=3 -> 0
        vecs.push_back(mk(1, 0, 2'd0, 4'b1111, 0, 4'b0000, 0, 8'h00, 2'd0)); // reset mid-op
        vecs.push_back(mk(1, 0, 2'd0, 4'b1111, 1, 4'b0000, 0, 8'h00, 2'd0));
        vecs.push_back(mk(0, 1, 2'd0, 4'b1111, 1, 4'b0001, 1, 8'h11, 2'd0)); // ptr reset to 0
        vecs.push_back(mk(0, 1, 2'd0, 4'b0010, 1, 4'b0010, 1, 8'h22, 2'd1));

        // Initial reset with requests pending: a_ready held low, outputs cleared.
        @(posedge clk);
        #1;
        rst = 1'b1; mode = 1'b0; sel = 2'd0; a_valid = 4'b1111; y_ready = 1'b1;
        #1;
        check("reset a_ready", {28'd0, a_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("reset y",       {24'd0, y},       32'd0);
        check("reset y_valid", {31'd0, y_valid}, 32'd0);
        check("reset grant",   {30'd0, grant},   32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

`ifdef MUX_NX1_REG_CNT_EN
        rst = 1'b1; mode = 1'b0; sel = 2'd0; a_valid = 4'b0000; y_ready = 1'b1;
        @(posedge clk);
        #1;
        check("cnt after reset", {16'd0, xfer_cnt}, 32'd0);
        // Five accepts fill then stream; a final drain cycle completes the fifth transfer.
        rst = 1'b0; a_valid = 4'b0001;
        repeat (5) @(posedge clk);
        #1;
        a_valid = 4'b0000;
        @(posedge clk);
        #1;
        check("cnt five", {16'd0, xfer_cnt}, 32'd5);

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; a_valid = 4'b0001; y_ready = 1'b1;
        repeat (65536) @(posedge clk);
        #1;
        check("cnt full", {16'd0, xfer_cnt}, 32'h0000_FFFF);
        @(posedge clk);
        #1;
        check("cnt wrap", {16'd0, xfer_cnt}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
